// File: rtl/ball_pkt_i2c_tx_seq_if.sv
// Byte-level I2C master command/status bundle.
// The sequencer drives commands through the master modport.
interface ball_pkt_i2c_tx_seq_if;
    logic       start;
    logic       stop;
    logic       i2c_en;
    logic [7:0] tx_data;
    logic       ready;
    logic       tx_done;

    modport master (
        output start, stop, i2c_en, tx_data,
        input  ready, tx_done
    );

    modport slave (
        input  start, stop, i2c_en, tx_data,
        output ready, tx_done
    );
endinterface

// File: rtl/ball_pkt_i2c_tx_seq.sv
// Ball packet transmit sequencer: snapshot ball state, then
// drive START, address, six payload bytes and STOP into the I2C master.
module ball_pkt_i2c_tx_seq #(
    parameter logic [6:0] SLV_ADDR  = 7'h42,
    parameter int         N_PAYLOAD = 6,
    parameter int         TIMEOUT   = 20000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ball_send_trigger,
    input  logic [9:0]                    ball_y,
    input  logic [7:0]                    ball_vy,
    input  logic [1:0]                    gravity_counter,
    input  logic                          is_collision,
    input  logic                          is_win_flag,
    ball_pkt_i2c_tx_seq_if.master         bus,
    output logic                          is_transfer,
    output logic                          is_i2c_master_done,
    output logic                          tx_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SEND,
        STOP,
        WAIT_RDY
    } state_t;

    state_t        state;
    logic [CW-1:0] tmr;
    logic [2:0]    idx;
    logic [47:0]   pkt;
    logic          pending;
    logic          go;
    logic          tmo;

    assign go  = (state == IDLE) && (ball_send_trigger || pending)
                 && bus.ready;
    assign tmo = (tmr == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            tmr                <= '0;
            idx                <= '0;
            pkt                <= '0;
            pending            <= 1'b0;
            bus.start          <= 1'b0;
            bus.stop           <= 1'b0;
            bus.i2c_en         <= 1'b0;
            bus.tx_data        <= 8'h00;
            is_transfer        <= 1'b0;
            is_i2c_master_done <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            bus.start          <= 1'b0;
            bus.stop           <= 1'b0;
            bus.i2c_en         <= 1'b0;
            is_i2c_master_done <= 1'b0;
            // Triggers that cannot be accepted now coalesce here
            pending <= !go && (pending || ball_send_trigger);

            unique case (state)
                IDLE: begin
                    if (go) begin
                        pkt <= {7'b0, is_win_flag,
                                7'b0, is_collision,
                                6'b0, gravity_counter,
                                ball_vy,
                                6'b0, ball_y[9:8],
                                ball_y[7:0]};
                        idx         <= '0;
                        tx_error    <= 1'b0;
                        is_transfer <= 1'b1;
                        bus.start   <= 1'b1;
                        bus.i2c_en  <= 1'b1;
                        bus.tx_data <= {SLV_ADDR, 1'b0};
                        state       <= START;
                    end
                end
                START: begin
                    tmr   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        bus.i2c_en <= 1'b1;
                        if (idx == 3'(N_PAYLOAD)) begin
                            bus.stop <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bus.tx_data <= pkt[7:0];
                            pkt         <= pkt >> 8;
                            idx         <= idx + 3'd1;
                            state       <= SEND;
                        end
                    end else if (tmo) begin
                        tx_error   <= 1'b1;
                        bus.stop   <= 1'b1;
                        bus.i2c_en <= 1'b1;
                        state      <= STOP;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                SEND: begin
                    tmr   <= '0;
                    state <= WAIT;
                end
                STOP: begin
                    tmr   <= '0;
                    state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    // An aborted packet ends without a done pulse
                    if (bus.ready) begin
                        is_i2c_master_done <= !tx_error;
                        is_transfer        <= 1'b0;
                        state              <= IDLE;
                    end else if (tmo) begin
                        tx_error    <= 1'b1;
                        is_transfer <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_pkt_i2c_tx_seq.sv
// Bench for ball_pkt_i2c_tx_seq: timestamp model of the packet
// schedule, a latency-based I2C master, and directed scenarios.
module tb_ball_pkt_i2c_tx_seq;

    localparam int         TO   = 50;
    localparam int         LAT  = 3;
    localparam logic [6:0] ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trig = 1'b0;
    logic [9:0] ball_y = '0;
    logic [7:0] ball_vy = '0;
    logic [1:0] grav = '0;
    logic       coll = 1'b0;
    logic       win = 1'b0;
    logic       is_transfer;
    logic       done;
    logic       tx_error;

    logic m_idle = 1'b1;
    logic hold_rdy = 1'b0;
    int   withhold = -1;

    ball_pkt_i2c_tx_seq_if bus ();
    assign bus.ready = m_idle & ~hold_rdy;

    ball_pkt_i2c_tx_seq #(
        .SLV_ADDR (ADDR),
        .N_PAYLOAD(6),
        .TIMEOUT  (TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ball_send_trigger (trig),
        .ball_y            (ball_y),
        .ball_vy           (ball_vy),
        .gravity_counter   (grav),
        .is_collision      (coll),
        .is_win_flag       (win),
        .bus               (bus),
        .is_transfer       (is_transfer),
        .is_i2c_master_done(done),
        .tx_error          (tx_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Master: each command keeps it busy LAT cycles, then acks or frees the bus
    int mcnt = 0;
    bit mstop = 0;
    bit mhold = 0;
    int mbyte = 0;
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (!reset) begin
                mcnt   = 0;
                m_idle = 1'b1;
            end else begin
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        if (mstop) m_idle = 1'b1;
                        else if (!mhold) bus.tx_done = 1'b1;
                    end
                end
                if (bus.i2c_en) begin
                    m_idle = 1'b0;
                    mcnt   = LAT;
                    mstop  = bus.stop;
                    if (bus.start) mbyte = -1;
                    else if (!bus.stop) mbyte++;
                    mhold = !bus.stop && !bus.start && (mbyte == withhold);
                end
            end
        end
    end

    typedef struct {
        int         cyc;
        bit         st;
        bit         sp;
        logic [7:0] d;
    } ev_t;
    ev_t logq[$];

    int cyc = 0;
    int n_start = 0, n_stop = 0, n_done = 0;
    int last_start = 0, rise_cyc = 0;
    bit prev_rdy = 0;

    // Model: packet as 8 timed strobes (addr, 6 bytes, stop)
    bit         m_busy = 0, m_pend = 0, m_err = 0;
    bit         ack_w = 0, rdy_w = 0, e_en;
    int         sched_at = -1, sidx = 0, wstart = 0, done_at = -1;
    logic [7:0] pkt[8];
    logic [7:0] cur_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            m_busy = 0; m_pend = 0; m_err = 0;
            ack_w = 0; rdy_w = 0;
            sched_at = -1; done_at = -1; cur_data = '0;
            chk("reset_outs", {bus.start, bus.stop, bus.i2c_en,
                bus.tx_data, is_transfer, done, tx_error}, 0);
        end else begin
            e_en = (cyc == sched_at);
            if (e_en && sidx < 7) cur_data = pkt[sidx];
            chk("i2c_en", bus.i2c_en, e_en);
            chk("start", bus.start, e_en && sidx == 0);
            chk("stop", bus.stop, e_en && sidx == 7);
            chk("tx_data", bus.tx_data, cur_data);
            chk("is_transfer", is_transfer, m_busy);
            chk("done", done, cyc == done_at);
            chk("tx_error", tx_error, m_err);
            if (bus.i2c_en)
                logq.push_back('{cyc, bus.start, bus.stop, bus.tx_data});
            if (bus.start) begin n_start++; last_start = cyc; end
            if (bus.stop) n_stop++;
            if (done) n_done++;
            if (bus.ready && !prev_rdy) rise_cyc = cyc;
            if (!m_busy) begin
                if ((trig || m_pend) && bus.ready) begin
                    pkt[0] = {ADDR, 1'b0};
                    pkt[1] = ball_y[7:0];
                    pkt[2] = {6'b0, ball_y[9:8]};
                    pkt[3] = ball_vy;
                    pkt[4] = {6'b0, grav};
                    pkt[5] = {7'b0, coll};
                    pkt[6] = {7'b0, win};
                    m_busy = 1; m_pend = 0; m_err = 0;
                    sidx = 0; sched_at = cyc + 1;
                end else if (trig) m_pend = 1;
            end else begin
                if (trig) m_pend = 1;
                if (cyc == sched_at) begin
                    wstart = cyc;
                    ack_w  = (sidx < 7);
                    rdy_w  = (sidx == 7);
                end else if (ack_w) begin
                    if (bus.tx_done) begin
                        ack_w = 0; sidx++; sched_at = cyc + 1;
                    end else if (cyc - wstart == TO) begin
                        ack_w = 0; m_err = 1; sidx = 7; sched_at = cyc + 1;
                    end
                end else if (rdy_w) begin
                    if (bus.ready) begin
                        rdy_w = 0; m_busy = 0;
                        if (!m_err) done_at = cyc + 1;
                    end else if (cyc - wstart == TO) begin
                        rdy_w = 0; m_busy = 0; m_err = 1;
                    end
                end
            end
        end
        prev_rdy = bus.ready;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (logq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (logq.size() < n) chk("wait_log_timeout", logq.size(), n);
    endtask

    task automatic wait_start(input int s0, input int budget);
        int k = 0;
        while (n_start <= s0 && k < budget) begin
            tick(1);
            k++;
        end
        if (n_start <= s0) chk("wait_start_timeout", n_start, s0 + 1);
    endtask

    logic [7:0] t1[7];
    int base, d0, s0;

    initial begin
        t1 = '{8'h84, 8'hA5, 8'h02, 8'hF3, 8'h02, 8'h01, 8'h00};
        #1 reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        chk("idle_transfer", is_transfer, 0);
        chk("idle_tx_data", bus.tx_data, 8'h00);

        // Nominal packet
        ball_y = 10'h2A5; ball_vy = 8'hF3; grav = 2'd2;
        coll = 1'b1; win = 1'b0;
        base = logq.size(); d0 = n_done;
        pulse();
        wait_log(base + 8, 300);
        tick(LAT + 4);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t1_byte%0d", i), logq[base + i].d, t1[i]);
        chk("t1_first_is_start", logq[base].st, 1);
        chk("t1_stop", logq[base + 7].sp, 1);
        chk("t1_done_once", n_done - d0, 1);

        // Inputs change right after accept
        base = logq.size();
        pulse();
        ball_y = 10'h001;
        wait_log(base + 8, 300);
        tick(LAT + 4);
        chk("t2_byte0", logq[base + 1].d, 8'hA5);
        chk("t2_byte1", logq[base + 2].d, 8'h02);

        // Triggers during transfer coalesce into one follow-up
        ball_y = 10'h2A5;
        base = logq.size(); s0 = n_start;
        pulse();
        tick(3); pulse(); tick(2); pulse(); tick(2); pulse();
        ball_y = 10'h3FF; ball_vy = 8'h11;
        wait_log(base + 16, 400);
        tick(40);
        chk("t3_starts", n_start - s0, 2);
        chk("t3_a_byte0", logq[base + 1].d, 8'hA5);
        chk("t3_b_start", logq[base + 8].st, 1);
        chk("t3_b_byte0", logq[base + 9].d, 8'hFF);
        chk("t3_b_byte1", logq[base + 10].d, 8'h03);
        chk("t3_b_byte2", logq[base + 11].d, 8'h11);

        // Withheld ack on payload byte 2 -> abort
        withhold = 2;
        base = logq.size(); d0 = n_done;
        pulse();
        wait_log(base + 5, 400);
        tick(LAT + 6);
        chk("t4_stop_flag", logq[base + 4].sp, 1);
        chk("t4_stop_delay", logq[base + 4].cyc - logq[base + 3].cyc, TO + 1);
        chk("t4_err_set", tx_error, 1);
        chk("t4_no_done", n_done - d0, 0);
        chk("t4_released", is_transfer, 0);
        withhold = -1;
        s0 = n_start;
        pulse();
        wait_start(s0, 20);
        chk("t4_err_cleared", tx_error, 0);
        tick(60);

        // Bus held busy while triggered
        hold_rdy = 1'b1;
        s0 = n_start;
        pulse();
        tick(29);
        chk("t5_no_start", n_start - s0, 0);
        hold_rdy = 1'b0;
        wait_start(s0, 10);
        chk("t5_start_lat", last_start - rise_cyc, 1);
        tick(60);

        // Reset mid-packet with a pending trigger
        base = logq.size();
        pulse();
        tick(2);
        pulse();
        wait_log(base + 5, 300);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_rst", {bus.start, bus.stop, bus.i2c_en, bus.tx_data,
            is_transfer, done, tx_error}, 0);
        tick(2);
        reset = 1'b1;
        s0 = n_start;
        tick(20);
        chk("t6_no_pending", n_start - s0, 0);
        chk("t6_idle", is_transfer, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_pkt_i2c_tx_seq.md
Name: ball_pkt_i2c_tx_seq

Overview:
Transmit-side sequencer for the inter-board ball packet. On a send trigger it snapshots the ball state, then drives the byte-level I2C master through START, address, six payload bytes and STOP. The far board's I2C slave receives these six bytes into its register file (y_pos0, y_pos1, y_vel, gravity, is_collision, is_win_flag). The block sits between the game logic and the I2C master, opposite that slave.

Parameters:
SLV_ADDR, 7'h42, 7-bit slave address; the address byte is {SLV_ADDR,1'b0}, write.
N_PAYLOAD, 6, payload byte count; fixed, do not override.
TIMEOUT, 20000, max clk cycles waiting on tx_done or ready before abort.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ball_send_trigger  in  1  one-cycle request to send a packet
ball_y  in  10  ball vertical position
ball_vy  in  8  ball vertical velocity, two's complement
gravity_counter  in  2  gravity phase
is_collision  in  1  paddle-collision flag
is_win_flag  in  1  point-won flag
ready  in  1  master idle, bus released
tx_done  in  1  master one-cycle pulse after each byte is ACKed
start  out  1  master START request, one cycle
stop  out  1  master STOP request, one cycle
i2c_en  out  1  master command strobe, one cycle
tx_data  out  8  byte to transmit
is_transfer  out  1  high from accept to STOP complete
is_i2c_master_done  out  1  one-cycle pulse on successful completion
tx_error  out  1  sticky timeout flag; cleared on next accepted trigger

Behaviour:
- Reset, async, active-low: state IDLE. start, stop, i2c_en, is_transfer, is_i2c_master_done, tx_error, and the pending flag all go to 0. tx_data goes to 8'h00. Byte index goes to 0.
- Snapshot taken in the accept cycle:
  - byte0 = ball_y[7:0]
  - byte1 = {6'b0, ball_y[9:8]}
  - byte2 = ball_vy
  - byte3 = {6'b0, gravity_counter}
  - byte4 = {7'b0, is_collision}
  - byte5 = {7'b0, is_win_flag}
- Input changes after accept do not affect the packet in flight.
- FSM:
  - IDLE: when (ball_send_trigger | pending) & ready, latch the snapshot, clear pending and tx_error, set is_transfer=1, go to START.
  - START: one cycle with start=1, i2c_en=1, tx_data={SLV_ADDR,0}. Go to WAIT.
  - WAIT: reset the timeout counter on entry and wait for tx_done.
    - On tx_done with index < 6: go to SEND.
    - On tx_done with index == 6: go to STOP.
  - SEND: one cycle with i2c_en=1, tx_data=byte[index], index++. Go to WAIT.
  - STOP: one cycle with stop=1, i2c_en=1. Go to WAIT_RDY.
  - WAIT_RDY: when ready=1, pulse is_i2c_master_done (only if no abort occurred), drop is_transfer, go to IDLE.
  - Timeout counter reaches TIMEOUT in WAIT: set tx_error=1, go to STOP. This is an abort with no done pulse.
  - Timeout in WAIT_RDY: set tx_error=1, drop is_transfer, go to IDLE.
- Latency, from accept with an ideal master:
  - start strobe 1 cycle after accept.
  - Each next i2c_en strobe 1 cycle after tx_done.
  - done pulse 1 cycle after ready is seen in WAIT_RDY.
- start, stop and i2c_en are single-cycle pulses and never assert in consecutive cycles.
- Trigger while is_transfer=1, or while ready=0 in IDLE: set pending, one-deep. Further triggers coalesce into the same pending flag. The pending packet uses a fresh snapshot at its own accept.
- Trigger in the same cycle as completion: it is captured as pending and the packet is sent next.
- tx_done outside WAIT is ignored.
- Reset mid-transfer: outputs return to reset values immediately. No STOP is issued; the master is reset by the same reset.

Test Plan:
- ball_y=10'h2A5, ball_vy=8'hF3, gravity=2, collision=1, win=0, with an ideal master model -> tx_data sequence 84, A5, 02, F3, 02, 01, 00; then a stop strobe; done pulses once; is_transfer spans the whole transfer.
- Change ball_y to 10'h001 one cycle after the trigger -> bytes still A5/02.
- Three triggers during a transfer -> exactly one additional packet follows, built from state at its accept.
- Master withholds tx_done after byte2 with TIMEOUT=50 -> after 50 cycles a stop strobe fires; tx_error=1; no done pulse; the next trigger clears tx_error.
- Trigger while ready=0 for 30 cycles -> start strobe 1 cycle after ready rises.
- Assert reset during byte3 -> all outputs 0 in the same cycle; IDLE and no pending after release.
